// File: rtl/mult_arbiter.sv
// mult_arbiter: four-port round-robin front end that shares one 16-bit multiplier.
// One operation in flight at a time; the result returns to the requester that issued it.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | arbitrate; accept the first requester at or after rr_ptr
//   ISSUE       | present operands with mult_input_STB until the multiplier takes them
//   WAIT_RESULT | ready for the multiplier output (mult_output_module_BUSY low)
//   DELIVER     | hold resp_STB[owner] and resp_result until the owner accepts
module mult_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_STB,
  output logic [3:0]  req_BUSY,
  output logic [15:0] resp_result,
  output logic [3:0]  resp_STB,
  input  logic [3:0]  resp_module_BUSY,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  output logic        mult_input_STB,
  input  logic        mult_BUSY,
  input  logic [15:0] mult_result,
  input  logic        mult_output_STB,
  output logic        mult_output_module_BUSY,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESULT,
    S_DELIVER
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_owner;
  logic [15:0] r_mult_a;
  logic [15:0] r_mult_b;
  logic        r_mult_input_STB;
  logic        r_mult_output_module_BUSY;
  logic [15:0] r_resp_result;
  logic [3:0]  r_resp_STB;
  logic [15:0] r_op_count;

  logic        w_found;
  logic [1:0]  w_winner;
  logic [1:0]  w_idx;

  // Round-robin pick: scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (req_STB[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Only the winner sees BUSY low, and only while arbitrating outside reset.
  always_comb begin
    req_BUSY = 4'b1111;
    if (!rst && r_state == S_IDLE && w_found) begin
      req_BUSY[w_winner] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; every transition is a completed handshake on one channel.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:        if (w_found)                    w_state_nxt = S_ISSUE;
      S_ISSUE:       if (!mult_BUSY)                 w_state_nxt = S_WAIT_RESULT;
      S_WAIT_RESULT: if (mult_output_STB)            w_state_nxt = S_DELIVER;
      S_DELIVER:     if (!resp_module_BUSY[r_owner]) w_state_nxt = S_IDLE;
      default:                                       w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs, updated on the same transfers as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr                  <= 2'd0;
      r_owner                   <= 2'd0;
      r_mult_a                  <= 16'd0;
      r_mult_b                  <= 16'd0;
      r_mult_input_STB          <= 1'b0;
      r_mult_output_module_BUSY <= 1'b1;
      r_resp_result             <= 16'd0;
      r_resp_STB                <= 4'd0;
      r_op_count                <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner          <= w_winner;
            r_mult_a         <= req_a[{w_winner, 4'b0000} +: 16];
            r_mult_b         <= req_b[{w_winner, 4'b0000} +: 16];
            r_mult_input_STB <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!mult_BUSY) begin
            r_mult_input_STB          <= 1'b0;
            r_mult_output_module_BUSY <= 1'b0;
          end
        end
        S_WAIT_RESULT: begin
          if (mult_output_STB) begin
            r_resp_result             <= mult_result;
            r_mult_output_module_BUSY <= 1'b1;
            r_resp_STB                <= 4'b0001 << r_owner;
          end
        end
        S_DELIVER: begin
          if (!resp_module_BUSY[r_owner]) begin
            r_resp_STB <= 4'd0;
            r_rr_ptr   <= r_owner + 2'd1;
            r_op_count <= r_op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_a                  = r_mult_a;
  assign mult_b                  = r_mult_b;
  assign mult_input_STB          = r_mult_input_STB;
  assign mult_output_module_BUSY = r_mult_output_module_BUSY;
  assign resp_result             = r_resp_result;
  assign resp_STB                = r_resp_STB;
  assign op_count                = r_op_count;

endmodule
